// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time. The row returns
// are synchronised and debounced, and each accepted press gives a 4-bit hex
// key code together with a single-cycle strobe.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous reset, active-low
//   row[3:0]  in   keypad row returns, active-low, asynchronous
//   col[3:0]  out  column drive, active-low, exactly one bit low
//   key_code  out  hex code of the last accepted key
//   key_valid out  one-cycle pulse when a press is accepted
//   key_down  out  high while the accepted key is held
module keypad_scanner #(
    parameter int SCAN_DIV       = 12000,  // clocks per column dwell, >= 4
    parameter int DEBOUNCE_SCANS = 10,     // matching samples to accept, >= 1
    parameter int CNT_W          = 14      // 2**CNT_W >= SCAN_DIV
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD
    } state_t;

    state_t           state, state_d;
    logic [3:0]       row_s1, row_s2;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       col_idx, col_idx_d;
    logic [DB_W-1:0]  db_cnt, db_cnt_d, db_next;
    logic [3:0]       pat, pat_d;
    logic [3:0]       key_code_d;
    logic             key_valid_d, key_down_d;
    logic             tick, one_low, all_high;

    // Maps a single-low row pattern plus the active column to the hex legend
    // printed on the keypad.
    function automatic logic [3:0] key_map(input logic [3:0] p, input logic [1:0] c);
        logic [1:0] r;
        logic [3:0] code;
        case (p)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign col      = ~(4'b0001 << col_idx);
    assign tick     = (cnt == CNT_W'(SCAN_DIV - 1));
    assign all_high = (row_s2 == 4'b1111);
    assign one_low  = (row_s2 == 4'b1110) || (row_s2 == 4'b1101) ||
                      (row_s2 == 4'b1011) || (row_s2 == 4'b0111);
    assign db_next  = db_cnt + DB_W'(1);

    // Sequential state: sync flops, dwell counter and FSM register.
    // NOTE: every register here uses <= so all flops update from the same
    // pre-edge values; blocking assignments would create ordering races.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_s1    <= 4'b1111;
            row_s2    <= 4'b1111;
            cnt       <= '0;
            state     <= SCAN;
            col_idx   <= 2'd0;
            db_cnt    <= '0;
            pat       <= 4'b1111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            row_s1    <= row;
            row_s2    <= row_s1;
            cnt       <= tick ? '0 : cnt + CNT_W'(1);
            state     <= state_d;
            col_idx   <= col_idx_d;
            db_cnt    <= db_cnt_d;
            pat       <= pat_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_down  <= key_down_d;
        end
    end

    // Next-state and output logic; row samples are only acted on at tick.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d     = state;
        col_idx_d   = col_idx;
        db_cnt_d    = db_cnt;
        pat_d       = pat;
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        key_down_d  = key_down;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low) begin
                        // Column is held while the pattern is debounced.
                        pat_d = row_s2;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_d  = key_map(row_s2, col_idx);
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            db_cnt_d    = '0;
                            state_d     = HELD;
                        end else begin
                            db_cnt_d = DB_W'(1);
                            state_d  = PRESS_DB;
                        end
                    end else begin
                        col_idx_d = col_idx + 2'd1;
                    end
                end
                PRESS_DB: begin
                    if (row_s2 == pat) begin
                        if (db_next == DB_W'(DEBOUNCE_SCANS)) begin
                            key_code_d  = key_map(pat, col_idx);
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            db_cnt_d    = '0;
                            state_d     = HELD;
                        end else begin
                            db_cnt_d = db_next;
                        end
                    end else begin
                        db_cnt_d  = '0;
                        col_idx_d = col_idx + 2'd1;
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    // Any low row, including a second key, restarts the
                    // release count; the original key stays held.
                    if (all_high) begin
                        if (db_next == DB_W'(DEBOUNCE_SCANS)) begin
                            key_down_d = 1'b0;
                            db_cnt_d   = '0;
                            col_idx_d  = col_idx + 2'd1;
                            state_d    = SCAN;
                        end else begin
                            db_cnt_d = db_next;
                        end
                    end else begin
                        db_cnt_d = '0;
                    end
                end
                default: begin
                    db_cnt_d = '0;
                    state_d  = SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A small keypad model pulls a row low whenever a pressed key's column is
// driven, so the DUT sees realistic row returns.
module tb_keypad_scanner;

    logic        clk;
    logic        reset_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    // pressed[r*4+c] = key at row r, column c is held down
    logic [15:0] pressed;

    int n_checks;
    int n_fail;

    // Results of the last watch() window
    int          pulses;
    int          first_pulse;
    logic [3:0]  pulse_code;
    logic        down_seen;
    logic [3:0]  cols_seen;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3),
        .CNT_W         (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reset asserted at a falling edge for n rising edges; returns at the
    // falling edge after the last reset edge, with the dwell counter at 0.
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Observe n clocks; k counts rising edges since the call.
    task automatic watch(input int n);
        pulses      = 0;
        first_pulse = -1;
        pulse_code  = 4'hx;
        down_seen   = 1'b0;
        cols_seen   = 4'b0000;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                pulse_code = key_code;
                if (first_pulse < 0) first_pulse = k;
            end
            if (key_down) down_seen = 1'b1;
            cols_seen = cols_seen | ~col;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic vd;
        logic done;
        n_checks = 0;
        n_fail   = 0;
        pressed  = 16'h0000;
        reset_n  = 1'b0;
        @(negedge clk);

        // 1: reset, no keys; columns rotate with a 4-clock dwell
        do_reset(2);
        check("reset_code", key_code, 4'h0);
        vd = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rot_col%0d", i), col, ~(32'd1 << (i / 4)) & 32'hF);
            vd = vd | key_valid | key_down;
            @(negedge clk);
        end
        check("idle_valid_down", vd, 1'b0);

        // 2: key '6' (r1,c2); first matching tick at edge 12, accept at 20
        pressed = 16'h0040;
        do_reset(2);
        watch(21);
        check("k6_pulses", pulses, 1);
        check("k6_latency", first_pulse, 20);
        check("k6_code", pulse_code, 4'h6);
        check("k6_down", key_down, 1'b1);
        check("k6_col_held", col, 4'b1011);
        check("k6_valid_low", key_valid, 1'b0);

        // 3: add '3' (r0,c2) in the same column while '6' is held
        pressed = 16'h0044;
        watch(40);
        check("two_pulses", pulses, 0);
        check("two_code", key_code, 4'h6);
        check("two_down", key_down, 1'b1);
        check("two_col", col, 4'b1011);
        pressed = 16'h0004;
        watch(20);
        check("partial_pulses", pulses, 0);
        check("partial_down", key_down, 1'b1);

        // 4: one-cycle reset while in HELD, key still pressed
        pressed = 16'h0040;
        do_reset(1);
        check("rst_held_col", col, 4'b1110);
        check("rst_held_code", key_code, 4'h0);
        check("rst_held_down", key_down, 1'b0);
        check("rst_held_valid", key_valid, 1'b0);
        watch(21);
        check("redetect_pulses", pulses, 1);
        check("redetect_latency", first_pulse, 20);
        check("redetect_code", pulse_code, 4'h6);

        // 5: release; 3 high ticks drop key_down and move to column 3
        pressed = 16'h0000;
        done = 1'b0;
        pulses = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (key_valid) pulses++;
            if (!key_down) done = 1'b1;
        end
        check("release_seen", done, 1'b1);
        check("release_pulses", pulses, 0);
        check("release_col", col, 4'b0111);
        check("release_code", key_code, 4'h6);

        // 6: bounce on '0' (r3,c1): 2 matching ticks, 1 absent, then stable
        pressed = 16'h2000;
        do_reset(2);
        pulses      = 0;
        first_pulse = -1;
        pulse_code  = 4'hx;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                pulse_code = key_code;
                if (first_pulse < 0) first_pulse = k;
            end
            if (k == 12) pressed = 16'h0000;
            if (k == 16) pressed = 16'h2000;
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_latency", first_pulse, 40);
        check("bounce_code", pulse_code, 4'h0);

        // 7: two rows low in column 0 (row=1001) is not a key
        pressed = 16'h0110;
        do_reset(2);
        watch(48);
        check("multi_pulses", pulses, 0);
        check("multi_down", down_seen, 1'b0);
        check("multi_cols", cols_seen, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
